// File: rtl/pulse_train_generator.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_generator
// Brief    : Periodic unit-impulse excitation source; the pitch period and
//            frame length are re-sampled only at LPC frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_generator #(
  parameter logic signed [15:0] AMPLITUDE = 16'sh4000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pulserate,
  input  logic [15:0]        lpcrate,
  output logic signed [15:0] pulseout
);

  logic [15:0] r_frame_cnt;
  logic [15:0] r_pitch_cnt;
  logic [15:0] r_period_q;
  logic [15:0] r_len_q;

  logic        w_frame_start;
  logic [15:0] w_eff_period;
  logic [15:0] w_eff_len;
  logic [16:0] w_pitch_inc;
  logic [16:0] w_frame_inc;
  logic        w_pitch_wrap;
  logic        w_frame_wrap;
  logic        w_pulse;

  // Live inputs are only honoured on the frame-start cycle; otherwise the
  // values latched at the last frame start govern.
  assign w_frame_start = (r_frame_cnt == 16'd0);
  assign w_eff_period  = w_frame_start ? pulserate : r_period_q;
  assign w_eff_len     = w_frame_start ? lpcrate   : r_len_q;

  // 17-bit compares; >= also folds a counter already past a newly shortened
  // period back to zero.
  assign w_pitch_inc  = {1'b0, r_pitch_cnt} + 17'd1;
  assign w_frame_inc  = {1'b0, r_frame_cnt} + 17'd1;
  assign w_pitch_wrap = (w_eff_period == 16'd0) || (w_pitch_inc >= {1'b0, w_eff_period});
  assign w_frame_wrap = (w_eff_len != 16'd0) && (w_frame_inc >= {1'b0, w_eff_len});
  assign w_pulse      = (r_pitch_cnt == 16'd0) && (w_eff_period != 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
      r_pitch_cnt <= 16'd0;
      r_period_q  <= 16'd0;
      r_len_q     <= 16'd0;
      pulseout    <= 16'sd0;
    end else begin
      pulseout <= w_pulse ? AMPLITUDE : 16'sd0;

      if (w_frame_start) begin
        r_period_q <= pulserate;
        r_len_q    <= lpcrate;
      end

      r_pitch_cnt <= w_pitch_wrap ? 16'd0 : w_pitch_inc[15:0];
      // Length 0 falls through to the natural 16-bit wrap: a 65536-clock frame.
      r_frame_cnt <= w_frame_wrap ? 16'd0 : w_frame_inc[15:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_generator
// Brief    : Self-checking bench for pulse_train_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_train_generator;

  localparam logic signed [15:0] AMP = 16'sh4000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [15:0]        pulserate = 16'd0;
  logic [15:0]        lpcrate = 16'd0;
  logic signed [15:0] pulseout;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model: frame position and pitch phase as plain integers.
  int m_phase, m_fpos, m_per, m_len;

  always #5 clk = ~clk;

  pulse_train_generator #(.AMPLITUDE(AMP)) dut (
    .clk(clk), .rst(rst), .pulserate(pulserate), .lpcrate(lpcrate), .pulseout(pulseout)
  );

  typedef struct {
    logic [15:0] pr;
    logic [15:0] lr;
    int          cycles;
    int          exp_pulses;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_fpos = 0; m_per = 0; m_len = 1;
  endtask

  task automatic model_step(output int expv);
    if (m_fpos == 0) begin
      m_per = int'(pulserate);
      m_len = (lpcrate == 16'd0) ? 65536 : int'(lpcrate);
    end
    expv    = (m_per != 0 && m_phase == 0) ? int'(AMP) : 0;
    m_phase = (m_per == 0 || m_phase + 1 >= m_per) ? 0 : m_phase + 1;
    m_fpos  = (m_fpos + 1) % m_len;
  endtask

  task automatic tick(output int got, output int expv);
    @(posedge clk);
    edge_n++;
    model_step(expv);
    #1 got = int'(pulseout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 chk("reset_out", int'(pulseout), 0);
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 chk("async_reset_out", int'(pulseout), 0);
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    vec_t tbl[6];
    int got, expv, cnt;

    tbl[0] = '{16'd4, 16'd240, 240, 60};
    tbl[1] = '{16'd0, 16'd240, 500, 0};
    tbl[2] = '{16'd1, 16'd10,  50,  50};
    tbl[3] = '{16'd7, 16'd0,   100, 15};
    tbl[4] = '{16'd3, 16'd5,   30,  10};
    tbl[5] = '{16'd2, 16'd1,   20,  10};

    for (int i = 0; i < 6; i++) begin
      pulserate = tbl[i].pr;
      lpcrate   = tbl[i].lr;
      do_reset();
      cnt = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        tick(got, expv);
        if (got == int'(AMP)) cnt++;
        if (c == 0) chk($sformatf("vec%0d_first_edge", i), got, (tbl[i].pr != 0) ? int'(AMP) : 0);
        chk($sformatf("vec%0d_edge%0d", i, edge_n), got, expv);
      end
      chk($sformatf("vec%0d_pulse_count", i), cnt, tbl[i].exp_pulses);
    end

    // Period 4 -> 7 mid-frame; takes effect at frame-start edge 241.
    pulserate = 16'd4; lpcrate = 16'd240;
    do_reset();
    for (int e = 1; e <= 300; e++) begin
      if (e == 100) pulserate = 16'd7;
      tick(got, expv);
      expv = (e < 241) ? (((e - 1) % 4 == 0) ? int'(AMP) : 0)
                       : (((e - 241) % 7 == 0) ? int'(AMP) : 0);
      chk($sformatf("change4to7_edge%0d", e), got, expv);
    end

    // Shorter period latched while pitch phase is 6: wrap at edge 237, pulse at 238.
    pulserate = 16'd10; lpcrate = 16'd236;
    do_reset();
    for (int e = 1; e <= 300; e++) begin
      if (e == 237) pulserate = 16'd3;
      tick(got, expv);
      if (e < 237)       expv = ((e - 1) % 10 == 0) ? int'(AMP) : 0;
      else if (e == 237) expv = 0;
      else               expv = ((e - 238) % 3 == 0) ? int'(AMP) : 0;
      chk($sformatf("shorten10to3_edge%0d", e), got, expv);
    end

    // Asynchronous reset mid-frame, held across an edge, then restart.
    pulserate = 16'd5; lpcrate = 16'd240;
    do_reset();
    for (int e = 1; e <= 47; e++) tick(got, expv);
    #2 rst = 1'b1;
    #1 chk("midframe_async_rst", int'(pulseout), 0);
    @(posedge clk);
    #1 chk("held_rst", int'(pulseout), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    edge_n = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(got, expv);
      chk($sformatf("post_rst_edge%0d", e), got, ((e - 1) % 5 == 0) ? int'(AMP) : 0);
    end

    // Randomized input changes checked against the reference model.
    pulserate = 16'd3; lpcrate = 16'd7;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick(got, expv);
      chk($sformatf("rand_cycle%0d", c), got, expv);
      if ($urandom_range(0, 7) == 0) pulserate = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) lpcrate   = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
